dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Shares the single data_mem port between two requesters: the RISCV core's load/store port (requester 0) and an external loader/debug port (requester 1). It does round-robin arbitration, with a bounded burst lock for requester 1. Sits between the core, the loader and data_mem inside the processor top level. Returns registered read data and gives the core a stall signal while it is not granted.

Parameters:
AW, 32, address width
DW, 32, data width
MAX_LOCK, 4, max consecutive locked grants to requester 1 while requester 0 waits (1..15)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
c_req  input  1  core access request
c_we  input  1  core write enable (1 = store, 0 = load)
c_addr  input  AW  core address
c_wdata  input  DW  core store data
c_gnt  output  1  core granted this cycle
c_stall  output  1  c_req & ~c_gnt
c_rvalid  output  1  core read data valid
c_rdata  output  DW  core read data
x_req  input  1  loader request
x_we  input  1  loader write enable
x_lock  input  1  loader requests to keep grant on next cycle (burst)
x_addr  input  AW  loader address
x_wdata  input  DW  loader write data
x_gnt  output  1  loader granted this cycle
x_rvalid  output  1  loader read data valid
x_rdata  output  DW  loader read data
mem_we  output  1  to data_mem write_en
mem_addr  output  AW  to data_mem addr
mem_wdata  output  DW  to data_mem write_data
mem_rdata  input  DW  from data_mem rd (combinational read)

Behaviour:
- Reset (reset=0, async): last_owner=1, lock_cnt=0, c_rvalid=x_rvalid=0, c_rdata=x_rdata=0. Grants are 0 while reset is asserted. A pending rvalid is discarded.
- Grant decision is combinational within the cycle, from req inputs, last_owner and lock state. At most one grant is high.
- Locked condition: last_owner=1, x_lock was sampled high on the previous x grant, and lock_cnt<MAX_LOCK.
  - If locked and x_req=1: x_gnt=1, regardless of c_req.
  - If locked and x_req=0: the lock releases and normal rules apply.
- Normal rules:
  - Only one requester active: grant it.
  - Both active: grant the requester != last_owner.
  - Neither active: no grant; last_owner is unchanged.
- Memory mux:
  - mem_addr/mem_wdata come from the granted requester; otherwise they hold the core's values.
  - mem_we = granted requester's we; it is 0 when there is no grant.
- Write commits to data_mem at the rising edge ending the grant cycle.
- Read latency is 1 cycle. On a granted read (we=0), mem_rdata is captured into the owner's rdata register at the edge, and rvalid pulses high for exactly the next cycle.
  - rdata holds its value until the next read to that requester.
  - A granted write produces no rvalid.
- Sequential updates at each edge with a grant:
  - last_owner <= granted id.
  - lock_cnt:
    - Increments (saturating at MAX_LOCK) on an x grant with x_lock=1 while c_req=1.
    - Clears on any c grant.
    - Clears on an x grant with x_lock=0.
  - Lock flag <= x_lock when x is granted; cleared when c is granted.
- Starvation bound: the core waits at most MAX_LOCK+1 cycles. When lock_cnt==MAX_LOCK and c_req=1, the core wins even if x_lock=1.
- If c_req=0, lock_cnt does not increment; the loader may burst indefinitely.
- Requesters must hold req/we/addr/wdata stable until granted. Dropping a req before grant is legal; no access occurs.
- Stall: c_stall=c_req&~c_gnt. The core freezes its PC and load/store while this is high.

Test Plan:
- Reset then core-only: c_req=1, c_we=1, c_addr=0x10, c_wdata=0xDEADBEEF -> c_gnt=1 on the same cycle, mem_we=1. A later core read of 0x10 -> c_rvalid=1 one cycle later with c_rdata=0xDEADBEEF.
- Simultaneous first request after reset: c_req=x_req=1 (reads) -> core granted cycle 1 and loader cycle 2 (alternating). c_stall=1 only in cycle 2 if the core re-requests.
- Loader burst without contention: x_req=x_lock=1 for 10 cycles, c_req=0 -> x_gnt=1 for all 10 cycles, lock_cnt stays 0.
- Burst with contention, MAX_LOCK=4: loader locked and core requesting -> loader gets 4 consecutive grants, then the core is granted on the 5th cycle. c_stall high for exactly 4 cycles.
- Lock release: x_lock drops to 0 while both request -> next grant goes to the core, lock_cnt=0.
- Async reset mid-read: reset asserted between the read grant and the rvalid edge -> rvalid stays 0. After release, all outputs are 0 and the first tie goes to the core.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Shares the single data_mem port between the core load/store port (id 0)
// and the external loader/debug port (id 1): round-robin with a bounded loader burst lock.
module dmem_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_LOCK = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_stall,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  input  logic          x_req,
  input  logic          x_we,
  input  logic          x_lock,
  input  logic [AW-1:0] x_addr,
  input  logic [DW-1:0] x_wdata,
  output logic          x_gnt,
  output logic          x_rvalid,
  output logic [DW-1:0] x_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [3:0] LOCK_LIMIT = 4'(MAX_LOCK);

  // Handshake: a requester holds req/we/addr/wdata until it sees gnt high in the
  // same cycle; the access completes at the edge ending that cycle, and a read
  // returns data with rvalid high for exactly the following cycle.

  logic       last_owner;
  logic       lock_flag;
  logic [3:0] lock_cnt;
  logic       locked;
  logic       c_win;
  logic       x_win;

  always_comb begin
    locked = last_owner & lock_flag & (lock_cnt < LOCK_LIMIT);
    c_win  = 1'b0;
    x_win  = 1'b0;
    if (locked && x_req) begin
      x_win = 1'b1;
    end else if (c_req && x_req) begin
      // Tie goes to whoever did not own the port last.
      if (last_owner) c_win = 1'b1;
      else            x_win = 1'b1;
    end else if (c_req) begin
      c_win = 1'b1;
    end else if (x_req) begin
      x_win = 1'b1;
    end
  end

  assign c_gnt   = c_win & reset;
  assign x_gnt   = x_win & reset;
  assign c_stall = c_req & ~c_gnt;

  assign mem_addr  = x_gnt ? x_addr  : c_addr;
  assign mem_wdata = x_gnt ? x_wdata : c_wdata;
  assign mem_we    = (c_gnt & c_we) | (x_gnt & x_we);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_owner <= 1'b1;
      lock_flag  <= 1'b0;
      lock_cnt   <= 4'd0;
      c_rvalid   <= 1'b0;
      x_rvalid   <= 1'b0;
      c_rdata    <= '0;
      x_rdata    <= '0;
    end else begin
      c_rvalid <= c_gnt & ~c_we;
      x_rvalid <= x_gnt & ~x_we;
      if (c_gnt && !c_we) c_rdata <= mem_rdata;
      if (x_gnt && !x_we) x_rdata <= mem_rdata;

      if (c_gnt) begin
        last_owner <= 1'b0;
        lock_flag  <= 1'b0;
        lock_cnt   <= 4'd0;
      end else if (x_gnt) begin
        last_owner <= 1'b1;
        lock_flag  <= x_lock;
        // Only contended locked grants count toward the core's starvation bound.
        if (!x_lock)
          lock_cnt <= 4'd0;
        else if (c_req && (lock_cnt < LOCK_LIMIT))
          lock_cnt <= lock_cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: grant/stall/mux checks per cycle and a
// read-data scoreboard drained by a monitor on the rvalid outputs.
module tb_dmem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          c_req = 1'b0, c_we = 1'b0;
  logic [AW-1:0] c_addr = '0;
  logic [DW-1:0] c_wdata = '0;
  logic          c_gnt, c_stall, c_rvalid;
  logic [DW-1:0] c_rdata;
  logic          x_req = 1'b0, x_we = 1'b0, x_lock = 1'b0;
  logic [AW-1:0] x_addr = '0;
  logic [DW-1:0] x_wdata = '0;
  logic          x_gnt, x_rvalid;
  logic [DW-1:0] x_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] c_exp_q[$];
  logic [DW-1:0] x_exp_q[$];
  logic [DW-1:0] dmem[0:63];
  logic [DW-1:0] ref_mem[0:63];

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(4)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_stall(c_stall), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .x_req(x_req), .x_we(x_we), .x_lock(x_lock), .x_addr(x_addr), .x_wdata(x_wdata),
    .x_gnt(x_gnt), .x_rvalid(x_rvalid), .x_rdata(x_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // clock / memory model
  always #5 clk = ~clk;

  assign mem_rdata = dmem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (mem_we) dmem[mem_addr[7:2]] <= mem_wdata;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: every rvalid pops one expected read word
  always @(negedge clk) begin
    if (reset) begin
      if (c_rvalid) begin
        if (c_exp_q.size() == 0) check("c_rvalid_unexpected", 32'(c_rvalid), 32'd0);
        else check("c_rdata", c_rdata, c_exp_q.pop_front());
      end
      if (x_rvalid) begin
        if (x_exp_q.size() == 0) check("x_rvalid_unexpected", 32'(x_rvalid), 32'd0);
        else check("x_rdata", x_rdata, x_exp_q.pop_front());
      end
    end
  end

  // driver: one cycle of requests with the hand-computed grant outcome
  task automatic step(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                      input logic xr, input logic xw, input logic xl,
                      input logic [31:0] xa, input logic [31:0] xd,
                      input logic ec, input logic ex);
    logic ewe;
    c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
    x_req = xr; x_we = xw; x_lock = xl; x_addr = xa; x_wdata = xd;
    @(negedge clk);
    ewe = (ec & cw) | (ex & xw);
    check("c_gnt", 32'(c_gnt), 32'(ec));
    check("x_gnt", 32'(x_gnt), 32'(ex));
    check("c_stall", 32'(c_stall), 32'(cr & ~ec));
    check("mem_we", 32'(mem_we), 32'(ewe));
    check("mem_addr", mem_addr, ex ? xa : ca);
    if (ec) begin
      if (cw) ref_mem[ca[7:2]] = cd;
      else    c_exp_q.push_back(ref_mem[ca[7:2]]);
    end
    if (ex) begin
      if (xw) ref_mem[xa[7:2]] = xd;
      else    x_exp_q.push_back(ref_mem[xa[7:2]]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 32'h10, 0, 0, 0, 0, 32'h20, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      dmem[i] = '0;
      ref_mem[i] = '0;
    end

    // reset: grants held off even with both requesting
    c_req = 1'b1; x_req = 1'b1;
    @(negedge clk);
    check("rst_c_gnt", 32'(c_gnt), 32'd0);
    check("rst_x_gnt", 32'(x_gnt), 32'd0);
    check("rst_c_rvalid", 32'(c_rvalid), 32'd0);
    check("rst_x_rvalid", 32'(x_rvalid), 32'd0);
    check("rst_c_rdata", c_rdata, 32'd0);
    check("rst_x_rdata", x_rdata, 32'd0);
    @(posedge clk); #1;
    c_req = 1'b0; x_req = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;

    // core-only write then read back
    step(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 32'h20, 0, 1, 0);
    step(1, 0, 32'h10, 0,            0, 0, 0, 32'h20, 0, 1, 0);
    idle();
    // loader-only write
    step(0, 0, 32'h10, 0, 1, 1, 0, 32'h20, 32'h12345678, 0, 1);
    // tie with last_owner=loader: core first, then loader while core stalls
    step(1, 0, 32'h10, 0, 1, 0, 0, 32'h20, 0, 1, 0);
    step(1, 0, 32'h10, 0, 1, 0, 0, 32'h20, 0, 0, 1);
    idle();

    // uncontended locked burst: loader owns every cycle, counter never moves
    for (int i = 0; i < 10; i++)
      step(0, 0, 32'h10, 0, 1, 1, 1, 32'h40 + 32'(i * 4), 32'hA000_0000 + 32'(i), 0, 1);

    // contended burst: 4 locked loader grants, core wins on the 5th cycle
    for (int i = 0; i < 4; i++)
      step(1, 0, 32'h10, 0, 1, 0, 1, 32'h40 + 32'(i * 4), 0, 0, 1);
    step(1, 0, 32'h10, 0, 1, 0, 1, 32'h50, 0, 1, 0);

    // lock release by x_lock dropping: one more loader grant, then the core
    step(1, 0, 32'h10, 0, 1, 0, 1, 32'h54, 0, 0, 1);
    step(1, 0, 32'h10, 0, 1, 0, 0, 32'h58, 0, 0, 1);
    step(1, 0, 32'h10, 0, 1, 0, 0, 32'h58, 0, 1, 0);
    // lock release by x_req dropping
    step(0, 0, 32'h10, 0, 1, 0, 1, 32'h5C, 0, 0, 1);
    step(1, 1, 32'h14, 32'hCAFE0001, 0, 0, 0, 32'h5C, 0, 1, 0);
    idle();
    idle();

    // async reset between a read grant and its capture edge
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10; x_req = 1'b0;
    @(negedge clk);
    check("midrd_c_gnt", 32'(c_gnt), 32'd1);
    #1 reset = 1'b0;
    #1;
    check("midrd_gnt_in_rst", 32'(c_gnt), 32'd0);
    check("midrd_stall_in_rst", 32'(c_stall), 32'd1);
    @(posedge clk); #1;
    check("midrd_c_rvalid", 32'(c_rvalid), 32'd0);
    check("midrd_c_rdata", c_rdata, 32'd0);
    check("midrd_x_rdata", x_rdata, 32'd0);
    c_req = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_c_gnt", 32'(c_gnt), 32'd0);
    check("post_rst_x_gnt", 32'(x_gnt), 32'd0);
    check("post_rst_mem_we", 32'(mem_we), 32'd0);
    check("post_rst_c_rvalid", 32'(c_rvalid), 32'd0);
    @(posedge clk); #1;
    // first tie after reset goes to the core
    step(1, 0, 32'h10, 0, 1, 0, 0, 32'h20, 0, 1, 0);
    step(1, 0, 32'h10, 0, 1, 0, 0, 32'h20, 0, 0, 1);
    idle();
    idle();

    check("c_queue_drained", 32'(c_exp_q.size()), 32'd0);
    check("x_queue_drained", 32'(x_exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
